// File: rtl/fusion_seq_ctrl_if.sv
// Handshake bundle between the fusion sequencer and its job source, subunit and result sink.
// master drives jobs, beats and out_ready; slave is the sequencer itself.
interface fusion_seq_ctrl_if #(
  parameter int COL_WIDTH = 13,
  parameter int ACC_WIDTH = 32,
  parameter int LEN_WIDTH = 8
);
  logic                   cfg_valid;
  logic                   cfg_ready;
  logic [1:0]             cfg_prec;
  logic                   cfg_sign;
  logic [LEN_WIDTH-1:0]   cfg_len;

  logic                   in_valid;
  logic                   in_ready;
  logic [2*COL_WIDTH-1:0] sum_in;

  logic [3:0]             shift;
  logic                   split_column;
  logic                   sign;

  logic                   out_valid;
  logic                   out_ready;
  logic [ACC_WIDTH-1:0]   out_acc0;
  logic [ACC_WIDTH-1:0]   out_acc1;
  logic                   busy;

  modport master (
    output cfg_valid, cfg_prec, cfg_sign, cfg_len, in_valid, sum_in, out_ready,
    input  cfg_ready, in_ready, shift, split_column, sign,
           out_valid, out_acc0, out_acc1, busy
  );

  modport slave (
    input  cfg_valid, cfg_prec, cfg_sign, cfg_len, in_valid, sum_in, out_ready,
    output cfg_ready, in_ready, shift, split_column, sign,
           out_valid, out_acc0, out_acc1, busy
  );
endinterface

// File: rtl/fusion_seq_ctrl.sv
// Job sequencer for the bit-fusion subunit: steps through shift/split settings and
// accumulates subunit sums into one or two lanes until the vector count is exhausted.
//
// state | meaning
// IDLE  | waiting for a job; cfg_ready high
// RUN   | consuming subunit beats; in_ready high
// DONE  | result held on out_acc0/1 until out_ready
module fusion_seq_ctrl #(
  parameter int COL_WIDTH = 13,
  parameter int ACC_WIDTH = 32,
  parameter int LEN_WIDTH = 8
) (
  input logic              clk,
  input logic              rst_n,
  fusion_seq_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e                 state_q;
  logic [1:0]             prec_q;
  logic                   sign_q;
  logic [LEN_WIDTH-1:0]   len_q;
  logic [1:0]             step_cnt_q, step_cnt_d;
  logic [LEN_WIDTH-1:0]   vec_cnt_q, vec_cnt_d;
  logic [ACC_WIDTH-1:0]   acc0_q, acc0_d;
  logic [ACC_WIDTH-1:0]   acc1_q, acc1_d;
  logic                   cfg_ready_q, in_ready_q, out_valid_q, busy_q;

  logic                   split;
  logic                   last_step;
  logic                   last_beat;
  logic [COL_WIDTH-1:0]   sum_lo, sum_hi;
  logic [ACC_WIDTH-1:0]   ext_full, ext_lo, ext_hi;

  assign split     = prec_q[1];
  assign last_step = (prec_q == 2'd0) ? (step_cnt_q == 2'd3) : 1'b1;
  assign last_beat = last_step && (vec_cnt_q == len_q);
  assign sum_lo    = bus.sum_in[COL_WIDTH-1:0];
  assign sum_hi    = bus.sum_in[2*COL_WIDTH-1:COL_WIDTH];

  always_comb begin
    if (sign_q) begin
      ext_full = ACC_WIDTH'($signed(bus.sum_in));
      ext_lo   = ACC_WIDTH'($signed(sum_lo));
      ext_hi   = ACC_WIDTH'($signed(sum_hi));
    end else begin
      ext_full = ACC_WIDTH'(bus.sum_in);
      ext_lo   = ACC_WIDTH'(sum_lo);
      ext_hi   = ACC_WIDTH'(sum_hi);
    end
  end

  // Wrapping accumulation; lane 1 only participates in split-column modes.
  always_comb begin
    acc0_d = acc0_q;
    acc1_d = acc1_q;
    if (split) begin
      acc0_d = acc0_q + ext_lo;
      acc1_d = acc1_q + ext_hi;
    end else begin
      acc0_d = acc0_q + ext_full;
    end
  end

  always_comb begin
    step_cnt_d = last_step ? 2'd0 : step_cnt_q + 2'd1;
    vec_cnt_d  = last_step ? vec_cnt_q + 1'b1 : vec_cnt_q;
  end

  always_comb begin
    bus.shift        = 4'd0;
    bus.split_column = 1'b0;
    bus.sign         = 1'b0;
    if (state_q != IDLE) begin
      bus.split_column = split;
      bus.sign         = sign_q;
      if (prec_q == 2'd0) begin
        case (step_cnt_q)
          2'd0:    bus.shift = 4'd0;
          2'd1:    bus.shift = 4'd4;
          2'd2:    bus.shift = 4'd4;
          default: bus.shift = 4'd8;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      prec_q      <= 2'd0;
      sign_q      <= 1'b0;
      len_q       <= '0;
      step_cnt_q  <= 2'd0;
      vec_cnt_q   <= '0;
      acc0_q      <= '0;
      acc1_q      <= '0;
      cfg_ready_q <= 1'b1;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.cfg_valid && cfg_ready_q) begin
            state_q     <= RUN;
            prec_q      <= bus.cfg_prec;
            sign_q      <= bus.cfg_sign;
            len_q       <= bus.cfg_len;
            step_cnt_q  <= 2'd0;
            vec_cnt_q   <= '0;
            acc0_q      <= '0;
            acc1_q      <= '0;
            cfg_ready_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b1;
          end
        end
        RUN: begin
          if (bus.in_valid && in_ready_q) begin
            acc0_q <= acc0_d;
            acc1_q <= acc1_d;
            // Counters freeze on the final beat so an all-ones length never wraps.
            if (last_beat) begin
              state_q     <= DONE;
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
            end else begin
              step_cnt_q <= step_cnt_d;
              vec_cnt_q  <= vec_cnt_d;
            end
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            cfg_ready_q <= 1'b1;
            busy_q      <= 1'b0;
          end
        end
        default: begin
          state_q     <= IDLE;
          cfg_ready_q <= 1'b1;
          in_ready_q  <= 1'b0;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.cfg_ready = cfg_ready_q;
  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;
  assign bus.out_acc0  = acc0_q;
  assign bus.out_acc1  = acc1_q;

endmodule

// File: tb/tb_fusion_seq_ctrl.sv
// Self-checking bench for fusion_seq_ctrl: directed job table, random jobs against a
// lane-sum reference model, and reset/back-pressure corner sequences.
module tb_fusion_seq_ctrl;

  logic clk;
  logic rst_n;

  fusion_seq_ctrl_if bus ();

  fusion_seq_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  logic [25:0] beats[$];

  typedef struct {
    string            name;
    logic [1:0]       prec;
    logic             sgn;
    int               len;
    int               nsum;
    logic [3:0][25:0] s;
    int               hold;
    logic [31:0]      e0;
    logic [31:0]      e1;
  } vec_t;

  vec_t tbl[6];

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endfunction

  function automatic longint ext(longint v, int w, logic sgn);
    if (sgn && v[w-1]) return v - (longint'(1) << w);
    return v;
  endfunction

  // Reference: sum every beat into its lane(s) with plain integer arithmetic, keep low 32 bits.
  function automatic void model(input logic [1:0] prec, input logic sgn,
                                output logic [31:0] e0, output logic [31:0] e1);
    longint a0 = 0;
    longint a1 = 0;
    foreach (beats[i]) begin
      if (prec >= 2) begin
        a0 += ext(longint'(beats[i][12:0]), 13, sgn);
        a1 += ext(longint'(beats[i][25:13]), 13, sgn);
      end else begin
        a0 += ext(longint'(beats[i]), 26, sgn);
      end
    end
    e0 = a0[31:0];
    e1 = a1[31:0];
  endfunction

  function automatic logic [3:0] exp_shift(logic [1:0] prec, int i);
    if (prec != 0) return 4'd0;
    case (i % 4)
      0:       return 4'd0;
      1, 2:    return 4'd4;
      default: return 4'd8;
    endcase
  endfunction

  task automatic run_job(input string tag, input logic [1:0] prec, input logic sgn,
                         input int len, input int hold, input bit gaps,
                         input logic [31:0] e0, input logic [31:0] e1);
    int nb;
    int w;
    nb = (len + 1) * ((prec == 0) ? 4 : 1);
    w = 0;
    while (!bus.cfg_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    check({tag, " cfg_ready idle"}, 64'(bus.cfg_ready), 64'd1);
    bus.cfg_valid = 1'b1;
    bus.cfg_prec  = prec;
    bus.cfg_sign  = sgn;
    bus.cfg_len   = len[7:0];
    @(negedge clk);
    bus.cfg_valid = 1'b0;
    bus.cfg_prec  = 2'($urandom);
    bus.cfg_sign  = 1'($urandom);
    bus.cfg_len   = 8'($urandom);
    check({tag, " busy run"}, 64'(bus.busy), 64'd1);
    check({tag, " cfg_ready run"}, 64'(bus.cfg_ready), 64'd0);
    for (int i = 0; i < nb; i++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          bus.in_valid  = 1'b0;
          bus.sum_in    = 26'($urandom);
          bus.cfg_valid = 1'($urandom);
          @(negedge clk);
        end
      end
      bus.in_valid = 1'b1;
      bus.sum_in   = beats[i];
      check($sformatf("%s in_ready b%0d", tag, i), 64'(bus.in_ready), 64'd1);
      check($sformatf("%s shift b%0d", tag, i), 64'(bus.shift), 64'(exp_shift(prec, i)));
      check($sformatf("%s split b%0d", tag, i), 64'(bus.split_column), 64'(prec >= 2));
      check($sformatf("%s sign b%0d", tag, i), 64'(bus.sign), 64'(sgn));
      @(negedge clk);
    end
    bus.in_valid  = 1'b0;
    bus.cfg_valid = 1'b0;
    check({tag, " out_valid latency"}, 64'(bus.out_valid), 64'd1);
    check({tag, " in_ready done"}, 64'(bus.in_ready), 64'd0);
    check({tag, " acc0"}, 64'(bus.out_acc0), 64'(e0));
    check({tag, " acc1"}, 64'(bus.out_acc1), 64'(e1));
    bus.cfg_valid = 1'b1;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check($sformatf("%s hold valid %0d", tag, h), 64'(bus.out_valid), 64'd1);
      check($sformatf("%s hold acc0 %0d", tag, h), 64'(bus.out_acc0), 64'(e0));
      check($sformatf("%s hold acc1 %0d", tag, h), 64'(bus.out_acc1), 64'(e1));
      check($sformatf("%s hold cfg_ready %0d", tag, h), 64'(bus.cfg_ready), 64'd0);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check({tag, " idle out_valid"}, 64'(bus.out_valid), 64'd0);
    check({tag, " idle cfg_ready"}, 64'(bus.cfg_ready), 64'd1);
    check({tag, " idle busy"}, 64'(bus.busy), 64'd0);
    bus.cfg_valid = 1'b0;
  endtask

  task automatic check_reset_values(string tag);
    check({tag, " cfg_ready"}, 64'(bus.cfg_ready), 64'd1);
    check({tag, " in_ready"}, 64'(bus.in_ready), 64'd0);
    check({tag, " out_valid"}, 64'(bus.out_valid), 64'd0);
    check({tag, " busy"}, 64'(bus.busy), 64'd0);
    check({tag, " acc0"}, 64'(bus.out_acc0), 64'd0);
    check({tag, " acc1"}, 64'(bus.out_acc1), 64'd0);
    check({tag, " shift"}, 64'(bus.shift), 64'd0);
    check({tag, " split"}, 64'(bus.split_column), 64'd0);
    check({tag, " sign"}, 64'(bus.sign), 64'd0);
  endtask

  initial begin
    logic [31:0] e0, e1;
    logic [1:0]  p;
    logic        sg;
    int          ln;

    tbl[0] = '{"u4_len2",   2'd1, 1'b0, 2, 3, {26'd0, 26'd30, 26'd20, 26'd10}, 0,
               32'd60, 32'd0};
    tbl[1] = '{"s8_len0",   2'd0, 1'b1, 0, 4, {26'h3FFFFFF, 26'd3, 26'd2, 26'd1}, 0,
               32'd5, 32'd0};
    tbl[2] = '{"u2_len1",   2'd2, 1'b0, 1, 2, {26'd0, 26'd0, 26'h000A003, 26'h000A003}, 0,
               32'd6, 32'd10};
    tbl[3] = '{"s1_split",  2'd3, 1'b1, 0, 1, {26'd0, 26'd0, 26'd0, 26'h3FFFFFE}, 5,
               32'hFFFFFFFE, 32'hFFFFFFFF};
    tbl[4] = '{"u8_len0",   2'd0, 1'b0, 0, 4, {26'h3FFFFFF, 26'd3, 26'd2, 26'd1}, 1,
               32'h04000005, 32'd0};
    tbl[5] = '{"s4_len1",   2'd1, 1'b1, 1, 2, {26'd0, 26'd0, 26'd5, 26'h3FFFFF0}, 2,
               32'hFFFFFFF5, 32'd0};

    bus.cfg_valid = 1'b0;
    bus.cfg_prec  = 2'd0;
    bus.cfg_sign  = 1'b0;
    bus.cfg_len   = 8'd0;
    bus.in_valid  = 1'b0;
    bus.sum_in    = '0;
    bus.out_ready = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    rst_n = 1'b1;
    @(negedge clk);

    foreach (tbl[k]) begin
      beats.delete();
      for (int j = 0; j < tbl[k].nsum; j++) beats.push_back(tbl[k].s[j]);
      run_job(tbl[k].name, tbl[k].prec, tbl[k].sgn, tbl[k].len, tbl[k].hold, 1'b0,
              tbl[k].e0, tbl[k].e1);
    end

    // Abort mid-job: partial sums must vanish and no result may appear.
    bus.cfg_valid = 1'b1;
    bus.cfg_prec  = 2'd0;
    bus.cfg_sign  = 1'b0;
    bus.cfg_len   = 8'd0;
    @(negedge clk);
    bus.cfg_valid = 1'b0;
    bus.in_valid  = 1'b1;
    bus.sum_in    = 26'd100;
    @(negedge clk);
    bus.sum_in    = 26'd200;
    @(negedge clk);
    bus.in_valid  = 1'b0;
    check("abort partial acc0", 64'(bus.out_acc0), 64'd300);
    #2 rst_n = 1'b0;
    #1 check_reset_values("abort");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("abort no out_valid", 64'(bus.out_valid), 64'd0);
    end
    beats.delete();
    for (int j = 0; j < 4; j++) beats.push_back(26'(j * 7 + 1));
    model(2'd0, 1'b0, e0, e1);
    run_job("post_abort", 2'd0, 1'b0, 0, 0, 1'b0, e0, e1);

    for (int r = 0; r < 30; r++) begin
      p  = 2'($urandom);
      sg = 1'($urandom);
      ln = $urandom_range(0, 4);
      beats.delete();
      for (int j = 0; j < (ln + 1) * ((p == 0) ? 4 : 1); j++) beats.push_back(26'($urandom));
      model(p, sg, e0, e1);
      run_job($sformatf("rnd%0d", r), p, sg, ln, $urandom_range(0, 3), 1'b1, e0, e1);
    end

    // Longest job: all-ones length must not wrap the vector counter.
    beats.delete();
    for (int j = 0; j < 256; j++) beats.push_back(26'($urandom));
    model(2'd1, 1'b0, e0, e1);
    run_job("len_max", 2'd1, 1'b0, 255, 0, 1'b0, e0, e1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
